// File: rtl/ram_stream_reader.sv
// Sweeps a RAM address window on start and streams the read data over valid/ready with a last-beat flag.
// Optional running checksum output when RAM_STREAM_READER_CHECKSUM_EN is defined.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
`ifdef RAM_STREAM_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam int CW = ADDR_WIDTH + 1;

  logic [1:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [CW-1:0]         len_reg;
  logic [CW-1:0]         issue_cnt_reg;
  logic [CW-1:0]         sent_cnt_reg;
  logic                  inflight_reg;
  logic                  wr_ptr_reg, rd_ptr_reg;
  logic [1:0]            count_reg;
  logic [DATA_WIDTH-1:0] entry_q [2];

  logic       start_ok, issue, last_issue, push, pop;
  logic [1:0] credit_used;

  assign start_ok    = (state_reg == ST_IDLE) && start;
  assign pop         = out_valid && out_ready;
  assign push        = inflight_reg;
  assign credit_used = count_reg + {1'b0, inflight_reg};
  // A beat leaving this cycle frees the slot the new read will land in two edges later.
  assign issue       = (state_reg == ST_RUN) &&
                       ((credit_used < 2'd2) || ((credit_used == 2'd2) && pop));
  assign last_issue  = issue && (issue_cnt_reg == len_reg - CW'(1));

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign ram_addr  = addr_reg;
  assign ram_we    = 1'b0;
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = entry_q[rd_ptr_reg];
  assign out_last  = out_valid && (sent_cnt_reg == len_reg - CW'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = (length == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_issue) state_next = ST_DRAIN;
      ST_DRAIN: if ((!inflight_reg && count_reg == 2'd0) || (pop && out_last))
                  state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      sent_cnt_reg  <= '0;
      inflight_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (start_ok) begin
        addr_reg      <= base_addr;
        len_reg       <= length;
        issue_cnt_reg <= '0;
        sent_cnt_reg  <= '0;
      end else begin
        if (issue) begin
          addr_reg      <= addr_reg + ADDR_WIDTH'(1);
          issue_cnt_reg <= issue_cnt_reg + CW'(1);
        end
        if (pop) sent_cnt_reg <= sent_cnt_reg + CW'(1);
      end
    end
  end

  // Two-entry output FIFO: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (!rst_n)
          entry_reg <= '0;
        else if (push && (wr_ptr_reg == 1'(gi)))
          entry_reg <= ram_q;
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

`ifdef RAM_STREAM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_reg;
  always_ff @(posedge clk) begin
    if (!rst_n)
      checksum_reg <= '0;
    else if (start_ok)
      checksum_reg <= '0;
    else if (pop)
      checksum_reg <= checksum_reg + out_data;
  end
  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized self-checking bench for ram_stream_reader against a queue-based model of the expected stream.
// Checksum checks are compiled in when RAM_STREAM_READER_CHECKSUM_EN is defined.
module tb_ram_stream_reader;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) ram_q <= mem[ram_addr];

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] exp_sum;
  bit  expecting_done = 0;
  bit  zero_len = 0;
  int  done_cnt = 0;
  int  ready_mode = 0;
  int  rdy_cnt = 0;

  task automatic check(input string name, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, expv, $time);
    end
  endtask

  // Downstream ready pattern, changed just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = (rdy_cnt >= 5) ? rdy_cnt[0] : 1'b0;
          rdy_cnt++;
        end
      endcase
    end
  end

  // Per-cycle compare against the expected word queue.
  initial begin
    bit prev_stall, prev_hs_last, hs;
    logic [DW-1:0] prev_data;
    logic prev_last;
    prev_stall = 0; prev_hs_last = 0; prev_data = '0; prev_last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        prev_hs_last = 0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(prev_data));
        check("stall_last", int'(out_last), int'(prev_last));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("stray_beat", int'(out_data), -1);
        else begin
          check("beat_data", int'(out_data), int'(exp_q[0]));
          check("beat_last", int'(out_last), int'(exp_q.size() == 1));
        end
      end else begin
        check("last_without_valid", int'(out_last), 0);
      end
      if (done) begin
        check("done_expected", int'(expecting_done), 1);
        if (!zero_len) check("done_after_last_beat", int'(prev_hs_last), 1);
        expecting_done = 0;
        done_cnt++;
      end
      hs = out_valid && out_ready;
      prev_hs_last = hs && out_last;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (hs) begin
        obs_q.push_back(out_data);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic load_model(input int base, input int len);
    exp_q.delete();
    obs_q.delete();
    exp_sum = '0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem[(base + i) % DEPTH]);
      exp_sum = exp_sum + mem[(base + i) % DEPTH];
    end
  endtask

  task automatic do_xfer(input int base, input int len, input int mode,
                         input bit check_lat, input bit poke_busy, input bit poke_done);
    int waited;
    load_model(base, len);
    ready_mode = mode;
    @(negedge clk);
    base_addr = AW'(base);
    length = (AW + 1)'(len);
    start = 1'b1;
    rdy_cnt = 0;
    zero_len = (len == 0);
    expecting_done = 1;
    @(negedge clk);
    start = 1'b0;
    base_addr = AW'($urandom);
    length = (AW + 1)'($urandom_range(0, DEPTH));
    check("busy_after_start", int'(busy), 1);
    if (check_lat) begin
      check("lat_valid_k1", int'(out_valid), 0);
      @(negedge clk);
      check("lat_valid_k2", int'(out_valid), 0);
      @(negedge clk);
      check("lat_valid_k3", int'(out_valid), 1);
    end
    waited = 0;
    while (!done && waited < 400) begin
      @(negedge clk);
      waited++;
      if (poke_busy && waited == 3) begin
        start = 1'b1; base_addr = 4'd9; length = 5'd3;
      end else if (poke_busy && waited == 4) begin
        start = 1'b0;
      end
    end
    check("done_seen", int'(done), 1);
    if (poke_done) begin
      start = 1'b1; base_addr = 4'd1; length = 5'd5;
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", int'(busy), 0);
    check("done_single_pulse", int'(done), 0);
    check("model_drained", exp_q.size(), 0);
    check("beat_count", obs_q.size(), len);
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    check("checksum", int'(checksum), int'(exp_sum));
`endif
    $display("xfer base=%0d len=%0d mode=%0d beats=%0d", base, len, mode, obs_q.size());
  endtask

  initial begin
    int d0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(8'h10 + i);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_addr", int'(ram_addr), 0);
    check("ram_we", int'(ram_we), 0);
    rst_n = 1'b1;

    do_xfer(2, 4, 0, 1, 0, 0);
    check("t1_b0", int'(obs_q[0]), 8'h12);
    check("t1_b3", int'(obs_q[3]), 8'h15);
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    check("t1_sum", int'(checksum), 8'h4E);
`endif
    do_xfer(14, 4, 0, 0, 0, 0);
    check("wrap_b1", int'(obs_q[1]), 8'h1F);
    check("wrap_b2", int'(obs_q[2]), 8'h10);
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    check("wrap_sum", int'(checksum), 8'h5E);
`endif
    do_xfer(5, 16, 0, 0, 0, 0);
    check("full_b0", int'(obs_q[0]), 8'h15);
    check("full_b10", int'(obs_q[10]), 8'h1F);
    check("full_b11", int'(obs_q[11]), 8'h10);
    check("full_b15", int'(obs_q[15]), 8'h14);

    do_xfer(0, 6, 2, 0, 0, 0);
    check("stall_b5", int'(obs_q[5]), 8'h15);
    do_xfer(7, 0, 0, 0, 0, 0);
    do_xfer(0, 8, 1, 0, 1, 1);
    check("poke_b7", int'(obs_q[7]), 8'h17);

    // Reset in the middle of a transfer.
    load_model(0, 10);
    ready_mode = 1;
    d0 = done_cnt;
    @(negedge clk);
    base_addr = 4'd0; length = 5'd10; start = 1'b1; zero_len = 0; expecting_done = 1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    exp_q.delete();
    expecting_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_done", done_cnt, d0);
    $display("xfer base=0 len=10 aborted by reset");

    do_xfer(3, 2, 0, 0, 0, 0);
    check("after_rst_b0", int'(obs_q[0]), 8'h13);
    check("after_rst_b1", int'(obs_q[1]), 8'h14);

    for (int t = 0; t < 14; t++)
      do_xfer($urandom_range(0, DEPTH - 1), (t % 7 == 3) ? 0 : $urandom_range(1, DEPTH),
              $urandom_range(0, 2), 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
